// File: rtl/out_port_scheduler_if.sv
// out_port_scheduler_if
//   Bundles the scheduler's request/credit inputs and its grant/select
//   outputs for one output port of the 5-port wormhole router.
//
//   Signals:
//     req[NUM_IN-1:0]    input i has a head flit targeting this port
//     tail[NUM_IN-1:0]   head flit of input i is a tail / single-flit flit
//     credit_ret         downstream freed one buffer slot this cycle
//     grant[NUM_IN-1:0]  one-hot owner of the port, 0 when idle
//     sel[2:0]           crossbar select, owner index + 1, 0 = none
//     fire               a flit transfers this cycle (pop strobe)
//     credits[CW-1:0]    current downstream credit count
//     busy               port is locked to an owner
//     timeout            sticky watchdog flag
//
//   Modports:
//     master - upstream / environment side (drives req, tail, credit_ret)
//     slave  - scheduler side (drives grant, sel, fire, credits, busy, timeout)

interface out_port_scheduler_if #(
  parameter int NUM_IN = 5,
  parameter int CW     = 3
);
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] tail;
  logic              credit_ret;
  logic [NUM_IN-1:0] grant;
  logic [2:0]        sel;
  logic              fire;
  logic [CW-1:0]     credits;
  logic              busy;
  logic              timeout;

  modport master (
    output req, tail, credit_ret,
    input  grant, sel, fire, credits, busy, timeout
  );

  modport slave (
    input  req, tail, credit_ret,
    output grant, sel, fire, credits, busy, timeout
  );
endinterface

// File: rtl/out_port_scheduler.sv
// out_port_scheduler
//   Per-output-port scheduler of the 5-port wormhole router. Arbitrates the
//   input buffers round-robin, locks the port to the winner until its tail
//   flit has been sent, and tracks downstream credits so no flit is sent
//   into a full neighbour.
//
//   Ports:
//     clk   rising-edge clock
//     RST   asynchronous reset, active-low
//     bus   out_port_scheduler_if.slave (req/tail/credit_ret in,
//           grant/sel/fire/credits/busy/timeout out)
//
//   Optional build macro:
//     SCHED_TIMEOUT_EN - enables the lock watchdog. A locked owner that
//     moves no flit for 16 consecutive cycles is released and the sticky
//     timeout flag is set. Without it, timeout is tied low and a lock
//     persists until the tail flit is sent.
//
//   State | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; arbitrate among requesters when credits are available
//   LOCK  | port owned by r_owner; flits move while owner requests and
//         | credits != 0; leave on tail fire (or watchdog expiry)

module out_port_scheduler #(
  parameter int NUM_IN     = 5,
  parameter int CREDIT_MAX = 4,
  parameter int CW         = 3
) (
  input logic                 clk,
  input logic                 RST,
  out_port_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_owner;
  logic [2:0]        r_rr_ptr;
  logic [NUM_IN-1:0] r_grant;
  logic [2:0]        r_sel;
  logic              r_busy;
  logic [CW-1:0]     r_credits;

`ifdef SCHED_TIMEOUT_EN
  logic [3:0]        r_lock_cnt;
  logic              r_timeout;
`endif

  logic [2:0]        w_winner;
  logic              w_found;
  logic [2:0]        w_idx;
  logic              w_cred_ok;
  logic              w_fire;
  logic              w_tail_fire;
  logic              w_force;
  logic              w_release;
  logic [CW-1:0]     w_credits_nxt;

  // Round-robin search starting just after the last released owner, so the
  // previous winner is always the last one considered.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      w_idx = 3'((32'(r_rr_ptr) + 32'(k)) % NUM_IN);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_cred_ok   = (r_credits != '0);
  assign w_fire      = (r_state == LOCK) && bus.req[r_owner] && w_cred_ok;
  assign w_tail_fire = w_fire && bus.tail[r_owner];

`ifdef SCHED_TIMEOUT_EN
  // A cycle that moves a flit clears the counter, so expiry only applies to
  // a full run of 16 idle lock cycles and never tears a moving packet.
  assign w_force = (r_state == LOCK) && !w_fire && (r_lock_cnt == 4'd15);
`else
  assign w_force = 1'b0;
`endif

  assign w_release = w_tail_fire || w_force;

  // Simultaneous fire and credit_ret cancel; returns at full depth are
  // dropped rather than wrapping the counter.
  always_comb begin
    w_credits_nxt = r_credits;
    if (w_fire && !bus.credit_ret) begin
      w_credits_nxt = r_credits - CW'(1);
    end else if (!w_fire && bus.credit_ret && (r_credits != CW'(CREDIT_MAX))) begin
      w_credits_nxt = r_credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= 3'd4;
      r_grant    <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_credits  <= CW'(CREDIT_MAX);
`ifdef SCHED_TIMEOUT_EN
      r_lock_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_credits <= w_credits_nxt;

      case (r_state)
        IDLE: begin
          if (w_found && w_cred_ok) begin
            r_owner <= w_winner;
            r_grant <= NUM_IN'(1) << w_winner;
            r_sel   <= w_winner + 3'd1;
            r_busy  <= 1'b1;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          // Non-owner requests are ignored here; a bubble from the owner
          // simply holds the lock.
          if (w_release) begin
            r_grant  <= '0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= r_owner;
            r_state  <= IDLE;
          end
        end
      endcase

`ifdef SCHED_TIMEOUT_EN
      if (r_state == LOCK) begin
        if (w_fire || w_force) begin
          r_lock_cnt <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt + 4'd1;
        end
        if (w_force) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_lock_cnt <= '0;
      end
`endif
    end
  end

  assign bus.grant   = r_grant;
  assign bus.sel     = r_sel;
  assign bus.fire    = w_fire;
  assign bus.credits = r_credits;
  assign bus.busy    = r_busy;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/out_port_scheduler.md
Name: out_port_scheduler

Overview:
Per-output-port scheduler for the 5-port wormhole router. It arbitrates the five input buffers competing for one output link, round-robin, and locks the output to the winner until its tail flit passes. It tracks downstream buffer credits so no flit is sent into a full neighbour. One instance sits beside each output buffer and drives the crossbar select for that port.

Parameters:
NUM_IN, 5, number of requesting inputs (fixed at 5 for the router; the select encoding is 1..5)
CREDIT_MAX, 4, downstream buffer depth in flits; credit counter reset value
CW, 3, credit counter width; must satisfy CREDIT_MAX < 2^CW

Ports:
clk  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-low
req  input  5  req[i]=1: input i has a valid flit at its head targeting this port
tail  input  5  tail[i]=1: the head flit of input i is a tail (or single-flit) flit; qualified by req[i]
credit_ret  input  1  downstream freed one slot this cycle
grant  output  5  registered one-hot owner of the port; 0 when idle
sel  output  3  registered crossbar select: owner index+1 (1..5), 0 = none
fire  output  1  combinational; a flit transfers this cycle (pop strobe to the owner's input buffer)
credits  output  CW  registered current credit count
busy  output  1  registered; 1 while state=LOCK
timeout  output  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- Reset (RST low, async): state=IDLE, grant=0, sel=0, busy=0, credits=CREDIT_MAX, rr_ptr=4, lock_cnt=0, timeout=0.
- Round-robin search order is rr_ptr+1, rr_ptr+2, ... modulo 5. After reset the order is therefore 0,1,2,3,4.
- IDLE state:
  - fire=0.
  - At a rising edge with |req=1 and credits!=0: the winner is the first requesting input in search order. Then owner<=winner, grant<=onehot(winner), sel<=winner+1, busy<=1, state<=LOCK.
  - The grant is visible in the next cycle. Head-to-grant latency is 1 cycle.
  - If credits==0, remain in IDLE even when req is nonzero.
- LOCK state:
  - fire = req[owner] & (credits!=0), combinational.
  - Requests from non-owner inputs are ignored.
  - If req[owner] drops mid-packet (bubble), remain locked with fire=0. This is the wormhole rule.
  - On fire & tail[owner]: at the edge, grant<=0, sel<=0, busy<=0, rr_ptr<=owner, state<=IDLE.
  - Re-arbitration happens in the following IDLE cycle. A 1-cycle gap between packets is required.
  - A single-flit packet (head=tail) is granted, fires once, and releases.
- Credits: credits_next = credits - fire + credit_ret.
  - fire and credit_ret in the same cycle leave credits unchanged.
  - credit_ret while credits==CREDIT_MAX is ignored (saturate, no wrap).
  - fire never occurs at credits==0, so there is no underflow.
- rr_ptr updates only on packet release. A winner therefore becomes lowest priority for the next arbitration.
- Mid-operation reset: all state returns to reset values immediately. Any partially sent packet is abandoned; the upstream buffers are flushed by the same reset.

Optional Feature:
Macro: SCHED_TIMEOUT_EN.
- Defined:
  - In LOCK, lock_cnt (4 bits) increments each cycle with fire=0 and clears on fire.
  - When lock_cnt reaches 15, the next edge forces release exactly as a tail release: grant=0, sel=0, busy=0, rr_ptr<=owner, state=IDLE, lock_cnt=0.
  - That edge also sets timeout<=1. timeout stays 1 until reset.
- Not defined: no watchdog logic; timeout is tied to 0 and LOCK persists indefinitely.

Test Plan:
- Reset, then req=5'b00100 with tail[2]=1 held 1 cycle after grant -> next cycle grant=5'b00100 and sel=3; fire=1 for one cycle; credits 4->3; then grant=0, sel=0.
- req=5'b11111 with single-flit packets on all inputs, credit_ret each cycle -> grant order inputs 0,1,2,3,4, repeating; each winner rotates to last.
- Input 1 sends a 3-flit packet (tail on the 3rd flit) while req[3]=1 throughout -> input 3 never granted until input 1's tail fires; sel=2 for all 3 flits.
- credits=0 with no credit_ret, owner requesting -> fire=0 and lock held; one credit_ret pulse -> fire=1 next cycle and credits stays 0 after the transfer.
- fire and credit_ret in the same cycle at credits=2 -> credits=2; credit_ret at credits=4 -> credits stays 4.
- SCHED_TIMEOUT_EN defined: owner drops req mid-packet for 16 cycles -> forced release at cycle 16, timeout=1 and sticky; the next requester is granted. Without the macro, grant is held and timeout=0.
